// File: rtl/apb_gpio_slave.sv
// APB3 GPIO slave: output and output-enable registers, synchronised inputs and a
// maskable level/edge interrupt, with programmable wait states on reads.
module apb_gpio_slave #(
  parameter int IO_NUM      = 32,
  parameter int READ_WAIT   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [7:0]        PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  input  logic [IO_NUM-1:0] GP_IN,
  output logic [IO_NUM-1:0] GP_OUT,
  output logic [IO_NUM-1:0] GP_OE,
  output logic              INT
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [5:0] A_DATA_OUT = 6'h00;
  localparam logic [5:0] A_OE       = 6'h01;
  localparam logic [5:0] A_DATA_IN  = 6'h02;
  localparam logic [5:0] A_INT_EN   = 6'h03;
  localparam logic [5:0] A_INT_TYPE = 6'h04;
  localparam logic [5:0] A_INT_STAT = 6'h05;
  localparam logic [3:0] RD_WAIT    = 4'(READ_WAIT);

  state_t            state_r, state_nxt_s;
  logic [3:0]        cnt_r, cnt_nxt_s;
  logic              pready_s, dec_err_s, wr_fire_s;
  logic [5:0]        addr_s;
  logic [31:0]       rdata_s;
  logic [IO_NUM-1:0] data_out_r, oe_r, int_en_r, int_type_r, int_stat_r;
  logic [IO_NUM-1:0] int_stat_nxt_s, event_s, clr_s, wdata_s;
  logic [IO_NUM-1:0] sync_r [SYNC_STAGES];
  logic [IO_NUM-1:0] sync_in_s, sync_d_r;
  logic              int_r;
  logic              unused_s;

  assign addr_s    = PADDR[7:2];
  assign wdata_s   = PWDATA[IO_NUM-1:0];
  assign unused_s  = ^{PADDR[1:0], PWDATA};
  assign wr_fire_s = pready_s & PWRITE & ~dec_err_s;

  // Transfer sequencing: setup -> counted access phase -> one-cycle completion
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    pready_s    = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (PSEL && !PENABLE) begin
          state_nxt_s = ST_WAIT;
          cnt_nxt_s   = PWRITE ? 4'd0 : RD_WAIT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!PSEL) begin
          state_nxt_s = ST_IDLE;
        end else if (PENABLE) begin
          if (cnt_r == 4'd0) begin
            pready_s    = 1'b1;
            state_nxt_s = ST_DONE;
          end else begin
            cnt_nxt_s = cnt_r - 4'd1;
          end
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Address decode and read mux; unmapped offsets flag an error and read 0
  always_comb begin
    dec_err_s = 1'b0;
    rdata_s   = 32'd0;
    case (addr_s)
      A_DATA_OUT: rdata_s[IO_NUM-1:0] = data_out_r;
      A_OE:       rdata_s[IO_NUM-1:0] = oe_r;
      A_DATA_IN:  rdata_s[IO_NUM-1:0] = sync_in_s;
      A_INT_EN:   rdata_s[IO_NUM-1:0] = int_en_r;
      A_INT_TYPE: rdata_s[IO_NUM-1:0] = int_type_r;
      A_INT_STAT: rdata_s[IO_NUM-1:0] = int_stat_r;
      default:    dec_err_s = 1'b1;
    endcase
  end

  // Set dominates clear so a persistent level source re-asserts at once
  assign sync_in_s      = sync_r[SYNC_STAGES-1];
  assign event_s        = (int_type_r & sync_in_s & ~sync_d_r) | (~int_type_r & sync_in_s);
  assign clr_s          = (wr_fire_s && (addr_s == A_INT_STAT)) ? wdata_s : '0;
  assign int_stat_nxt_s = (int_stat_r & ~clr_s) | (event_s & int_en_r);

  // FSM state and wait counter
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Register file, input synchroniser, edge history and interrupt flop
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      data_out_r <= '0;
      oe_r       <= '0;
      int_en_r   <= '0;
      int_type_r <= '0;
      int_stat_r <= '0;
      sync_d_r   <= '0;
      int_r      <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) sync_r[i] <= '0;
    end else begin
      sync_r[0] <= GP_IN;
      for (int i = 1; i < SYNC_STAGES; i++) sync_r[i] <= sync_r[i-1];
      sync_d_r   <= sync_in_s;
      int_stat_r <= int_stat_nxt_s;
      int_r      <= |int_stat_r;
      if (wr_fire_s) begin
        case (addr_s)
          A_DATA_OUT: data_out_r <= wdata_s;
          A_OE:       oe_r       <= wdata_s;
          A_INT_EN:   int_en_r   <= wdata_s;
          A_INT_TYPE: int_type_r <= wdata_s;
          default:    ;
        endcase
      end
    end
  end

  assign PREADY  = pready_s;
  assign PSLVERR = pready_s & dec_err_s;
  assign PRDATA  = (pready_s && !PWRITE) ? rdata_s : 32'd0;
  assign GP_OUT  = data_out_r;
  assign GP_OE   = oe_r;
  assign INT     = int_r;

endmodule

// File: tb/tb_apb_gpio_slave.sv
// Directed bench for apb_gpio_slave: APB transfers with wait-state counting,
// GPIO input sampling, edge/level interrupts, decode errors and mid-transfer reset.
module tb_apb_gpio_slave;

  logic        PCLK = 1'b0;
  logic        PRESET, PSEL, PENABLE, PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA, PRDATA;
  logic        PREADY, PSLVERR, INT;
  logic [31:0] GP_IN, GP_OUT, GP_OE;

  int checks = 0;
  int errors = 0;

  apb_gpio_slave #(.IO_NUM(32), .READ_WAIT(3), .SYNC_STAGES(2)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .GP_IN(GP_IN), .GP_OUT(GP_OUT), .GP_OE(GP_OE), .INT(INT)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "simulation time limit reached");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_err, input int exp_waits,
                      input string tag);
    int waits;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    waits = 0;
    @(negedge PCLK);
    while (PREADY !== 1'b1 && waits < 32) begin
      waits++;
      @(negedge PCLK);
    end
    chk({tag, ".waits"}, 32'(waits), 32'(exp_waits));
    chk({tag, ".ready"}, {31'd0, PREADY}, 32'd1);
    chk({tag, ".err"}, {31'd0, PSLVERR}, {31'd0, exp_err});
    chk({tag, ".rdata"}, PRDATA, wr ? 32'd0 : exp_rdata);
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    @(negedge PCLK);
    chk({tag, ".prdata"}, PRDATA, 32'd0);
    chk({tag, ".pready"}, {31'd0, PREADY}, 32'd0);
    chk({tag, ".pslverr"}, {31'd0, PSLVERR}, 32'd0);
    chk({tag, ".gp_out"}, GP_OUT, 32'd0);
    chk({tag, ".gp_oe"}, GP_OE, 32'd0);
    chk({tag, ".int"}, {31'd0, INT}, 32'd0);
  endtask

  initial begin
    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = 8'h00; PWDATA = 32'd0; GP_IN = 32'd0;
    cycles(3);
    PRESET = 1'b0;
    chk_idle_outputs("reset");

    // 1: zero-wait writes drive the pins
    xfer(1'b1, 8'h00, 32'hA5A5_A5A5, 32'd0, 1'b0, 0, "wr_dout");
    xfer(1'b1, 8'h04, 32'hFFFF_0000, 32'd0, 1'b0, 0, "wr_oe");
    chk("gp_out", GP_OUT, 32'hA5A5_A5A5);
    chk("gp_oe", GP_OE, 32'hFFFF_0000);

    // 2: reads take exactly three wait cycles, back to back
    xfer(1'b0, 8'h00, 32'd0, 32'hA5A5_A5A5, 1'b0, 3, "rd_dout");
    xfer(1'b0, 8'h04, 32'd0, 32'hFFFF_0000, 1'b0, 3, "rd_oe");

    // 3: synchronised input, DATA_IN is read-only
    GP_IN = 32'h0000_0081;
    cycles(3);
    xfer(1'b0, 8'h08, 32'd0, 32'h0000_0081, 1'b0, 3, "rd_din");
    xfer(1'b1, 8'h08, 32'hFFFF_FFFF, 32'd0, 1'b0, 0, "wr_din");
    xfer(1'b0, 8'h08, 32'd0, 32'h0000_0081, 1'b0, 3, "rd_din2");

    // 4: rising-edge interrupt, clear, no re-set while held high
    GP_IN = 32'h0000_0080;
    cycles(4);
    xfer(1'b1, 8'h10, 32'h0000_0001, 32'd0, 1'b0, 0, "wr_itype");
    xfer(1'b1, 8'h0C, 32'h0000_0001, 32'd0, 1'b0, 0, "wr_ien");
    cycles(3);
    @(negedge PCLK);
    chk("int_quiet", {31'd0, INT}, 32'd0);
    GP_IN = 32'h0000_0081;
    cycles(6);
    chk("int_edge", {31'd0, INT}, 32'd1);
    xfer(1'b0, 8'h14, 32'd0, 32'h0000_0001, 1'b0, 3, "rd_stat_edge");
    xfer(1'b1, 8'h14, 32'h0000_0001, 32'd0, 1'b0, 0, "clr_stat_edge");
    @(negedge PCLK);
    chk("int_lag", {31'd0, INT}, 32'd1);
    @(posedge PCLK); #1;
    chk("int_cleared", {31'd0, INT}, 32'd0);
    xfer(1'b0, 8'h14, 32'd0, 32'd0, 1'b0, 3, "rd_stat_held");
    chk("int_held", {31'd0, INT}, 32'd0);

    // 5: level mode, set wins over clear
    xfer(1'b1, 8'h10, 32'd0, 32'd0, 1'b0, 0, "wr_itype_lvl");
    cycles(3);
    chk("int_level", {31'd0, INT}, 32'd1);
    xfer(1'b1, 8'h14, 32'h0000_0001, 32'd0, 1'b0, 0, "clr_stat_lvl");
    xfer(1'b0, 8'h14, 32'd0, 32'h0000_0001, 1'b0, 3, "rd_stat_lvl");
    chk("int_level_hold", {31'd0, INT}, 32'd1);

    // 6: decode errors leave state untouched
    xfer(1'b0, 8'h40, 32'd0, 32'd0, 1'b1, 3, "rd_bad");
    xfer(1'b1, 8'h40, 32'h1234_5678, 32'd0, 1'b1, 0, "wr_bad");
    xfer(1'b0, 8'h00, 32'd0, 32'hA5A5_A5A5, 1'b0, 3, "rd_dout_post");
    chk("gp_oe_post", GP_OE, 32'hFFFF_0000);

    // 6b: reset during a read's wait state
    GP_IN = 32'd0;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 8'h04;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(negedge PCLK);
    chk("mid_rd_wait", {31'd0, PREADY}, 32'd0);
    @(posedge PCLK); #1;
    PRESET = 1'b1;
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    chk_idle_outputs("mid_reset");
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    cycles(1);
    xfer(1'b1, 8'h04, 32'h0000_FFFF, 32'd0, 1'b0, 0, "wr_oe_after");
    xfer(1'b0, 8'h04, 32'd0, 32'h0000_FFFF, 1'b0, 3, "rd_oe_after");
    xfer(1'b0, 8'h00, 32'd0, 32'd0, 1'b0, 3, "rd_dout_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_gpio_slave.md
Name: apb_gpio_slave

Overview:
APB3 slave GPIO register block that consumes the PSEL/PADDR/PENABLE/PWRITE/PWDATA stream produced by the AHB-Lite-to-APB bridge stage and returns PRDATA/PREADY/PSLVERR to it. It drives GPIO outputs and output enables, samples synchronised GPIO inputs, and generates a maskable interrupt from input events. Reads insert programmable wait states so the bridge's PREADY path is exercised.

Parameters:
IO_NUM, 32, number of GPIO bits (1..32); register bits above IO_NUM-1 read 0 and ignore writes.
READ_WAIT, 1, wait states inserted on reads (0..15); writes are always zero-wait.
SYNC_STAGES, 2, flops in the GP_IN synchroniser (2..3).

Ports:
PCLK  in  1  single clock for all logic.
PRESET  in  1  synchronous, active-high reset.
PSEL  in  1  slave select from bridge.
PENABLE  in  1  APB access phase.
PWRITE  in  1  1=write, 0=read.
PADDR  in  8  byte address; PADDR[1:0] ignored.
PWDATA  in  32  write data.
PRDATA  out  32  read data.
PREADY  out  1  transfer complete.
PSLVERR  out  1  error response, valid only when PREADY=1.
GP_IN  in  IO_NUM  asynchronous GPIO inputs.
GP_OUT  out  IO_NUM  GPIO output values.
GP_OE  out  IO_NUM  GPIO output enables.
INT  out  1  interrupt request, active high.

Behaviour:
- Reset: sampled on PCLK rising edge with PRESET=1. All registers, synchroniser flops, edge history and wait counter go to 0; FSM goes to IDLE. Outputs after reset: PRDATA=0, PREADY=0, PSLVERR=0, GP_OUT=0, GP_OE=0, INT=0.
- Reset mid-transfer: the transfer is abandoned with no register update. The bridge must restart with a fresh setup phase.
- Register map (PADDR[7:2]):
  - 0x00 DATA_OUT: RW.
  - 0x04 OE: RW.
  - 0x08 DATA_IN: RO, synchronised inputs; writes are ignored, no error.
  - 0x0C INT_EN: RW.
  - 0x10 INT_TYPE: RW; bit=0 level-high, bit=1 rising-edge.
  - 0x14 INT_STAT: read / write-1-to-clear.
  - Any other offset: decode error.
- FSM states: IDLE, WAIT, DONE.
  - IDLE: on PSEL=1 & PENABLE=0 (setup phase), load the wait counter with READ_WAIT when PWRITE=0, else with 0. Go to WAIT.
  - WAIT: with PSEL=1 & PENABLE=1, decrement the counter each cycle. PREADY is combinational 1 while the counter is 0. A write in its first access cycle therefore completes with zero waits. A read completes after exactly READ_WAIT cycles with PREADY=0.
  - When PREADY=1: writes update the addressed register on that edge. PRDATA carries the register value for reads and 0 otherwise. PSLVERR=1 for decode errors. Next state is DONE.
  - DONE: PREADY=0. Go to IDLE; a back-to-back setup phase in the same cycle is accepted directly into WAIT.
  - PSEL dropping during WAIT is a protocol violation: return to IDLE with no update.
- Errored writes leave all registers unchanged. Errored reads return PRDATA=0.
- Input path: GP_IN passes through SYNC_STAGES flops, giving sync_in. An extra flop holds sync_d for edge detection.
  - Level-mode event = sync_in.
  - Edge-mode event = sync_in & ~sync_d.
  - Input-to-DATA_IN latency is SYNC_STAGES cycles.
- INT_STAT bit i:
  - set when event[i] & INT_EN[i];
  - cleared by a write with PWDATA[i]=1 to 0x14;
  - if set and clear occur in the same cycle, set wins.
  - A level-mode source held high therefore re-asserts immediately after clear.
- INT is registered: the OR of INT_STAT, delayed one cycle.
- GP_OUT = DATA_OUT and GP_OE = OE, both direct from their registers; they change the cycle after the write edge.

Test Plan:
1. Reset, then write 0xA5A5_A5A5 to 0x00 and 0xFFFF_0000 to 0x04 -> each write has PREADY=1 on its first access cycle, PSLVERR=0; GP_OUT=0xA5A5A5A5, GP_OE=0xFFFF0000.
2. With READ_WAIT=3, read 0x00 -> exactly 3 access cycles with PREADY=0, then PREADY=1 with PRDATA=0xA5A5A5A5; back-to-back read of 0x04 returns 0xFFFF0000.
3. Drive GP_IN=0x0000_0081 -> read of 0x08 issued ≥SYNC_STAGES cycles later returns 0x81; write 0xFFFFFFFF to 0x08 -> no error, value unchanged.
4. INT_EN=0x1, INT_TYPE=0x1, pulse GP_IN[0] 0->1 -> INT_STAT=0x1, INT=1; write 0x1 to 0x14 -> INT_STAT=0, INT=0 one cycle later; holding GP_IN[0]=1 does not re-set the bit.
5. Level mode (INT_TYPE=0), GP_IN[0] held high, write 0x1 to 0x14 -> INT_STAT reads 0x1 (set wins); INT stays 1.
6. Read and write 0x40 -> PSLVERR=1 with PREADY; read data 0; no register changes. Assert PRESET during a read's wait state -> all outputs 0, FSM in IDLE, next transfer completes normally.
